// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
// Define CLA_PIPE_SAT_EN to saturate s to the signed limit on overflow.
module pipelined_cla_adder #(
  parameter int WIDTH            = 16,
  parameter int GROUP            = 4,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SW      = GROUP * GROUPS_PER_STAGE;
  localparam int NSTAGES = WIDTH / SW;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // One enable for the whole pipe: it only stalls when the output is held.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;

  // Returns {carry_out, sum} for one stage slice: full lookahead inside each
  // group, groups rippled within the stage.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    logic [SW-1:0] g, p, sum;
    logic [GROUP:0] c;
    logic carry, t;
    // NOTE: blocking assignments are correct here: this is pure combinational
    // evaluation inside a function, each statement building on the previous.
    g     = x & y;
    p     = x ^ y;
    sum   = '0;
    carry = ci;
    for (int grp = 0; grp < GROUPS_PER_STAGE; grp++) begin
      for (int i = 0; i <= GROUP; i++) begin
        c[i] = carry;
        for (int m = 0; m < i; m++) c[i] = c[i] & p[grp*GROUP+m];
        for (int j = 0; j < i; j++) begin
          t = g[grp*GROUP+j];
          for (int m = j + 1; m < i; m++) t = t & p[grp*GROUP+m];
          c[i] = c[i] | t;
        end
      end
      for (int i = 0; i < GROUP; i++) sum[grp*GROUP+i] = p[grp*GROUP+i] ^ c[i];
      carry = c[GROUP];
    end
    return {carry, sum};
  endfunction

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k * SW;  // operand bits still to be added
    localparam int LO  = (k + 1) * SW;    // sum bits finished after this stage

    logic [REM-1:0] a_in, b_in;
    logic           c_in, v_in, v_q, c_q, load;
    logic [SW:0]    res;
    logic [LO-1:0]  sum_d, sum_st, sum_q;

    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign sum_d = res[SW-1:0];
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_rem.a_q;
      assign b_in  = g_stage[k-1].g_rem.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign sum_d = {res[SW-1:0], g_stage[k-1].sum_q};
    end

    assign res  = slice_add(a_in[SW-1:0], b_in[SW-1:0], c_in);
    // Data only moves with a valid beat, so bubbles never disturb held values.
    assign load = en & v_in;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (en) begin
        v_q <= v_in;
        if (v_in) begin
          sum_q <= sum_st;
          c_q   <= res[SW];
        end
      end
    end

    if (k < NSTAGES - 1) begin : g_rem
      logic [REM-SW-1:0] a_q, b_q;

      // NOTE: skewed operand registers are always qualified by v_q downstream,
      // so they carry no reset.
      always_ff @(posedge clk) begin
        if (load) begin
          a_q <= a_in[REM-1:SW];
          b_q <= b_in[REM-1:SW];
        end
      end

      assign sum_st = sum_d;
    end else begin : g_last
      logic c_msb, ovf_d, ovf_q;

      // Carry into the MSB recovered from its sum bit: sum = p ^ carry.
      assign c_msb = a_in[REM-1] ^ b_in[REM-1] ^ res[SW-1];
      assign ovf_d = c_msb ^ res[SW];

`ifdef CLA_PIPE_SAT_EN
      assign sum_st = ovf_d ? {a_in[REM-1], {(WIDTH-1){~a_in[REM-1]}}} : sum_d;
`else
      assign sum_st = sum_d;
`endif

      always_ff @(posedge clk) begin
        if (rst)       ovf_q <= 1'b0;
        else if (load) ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = g_stage[NSTAGES-1].v_q;
  assign s         = g_stage[NSTAGES-1].sum_q;
  assign cout      = g_stage[NSTAGES-1].c_q;
  assign ovf       = g_stage[NSTAGES-1].g_last.ovf_q;

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface, for the multiplier datapath (final partial-product add, accumulate).
- Operands are split into GROUP-bit lookahead groups, with GROUPS_PER_STAGE groups per pipeline stage.
- Carry is registered between stages. Operand slices not yet consumed are skewed forward, and finished sum slices are carried along to the output.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP*GROUPS_PER_STAGE.
- GROUP, 4, bits per lookahead group (full internal lookahead within a group).
- GROUPS_PER_STAGE, 2, groups rippled combinationally within one pipeline stage.
- Derived NSTAGES = WIDTH/(GROUP*GROUPS_PER_STAGE); default 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: A+B+cin; 1: A-B-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference.
- cout  out  1  raw carry out of MSB (in sub mode 1 = no borrow).
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset: all stage valid bits, s, cout, ovf, out_valid = 0. Reset dominates every other input in the same cycle. In-flight beats are discarded and never emerge.
- Operand conditioning at input: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. Arithmetic is modulo 2^WIDTH.
- Per group: g = a&b_eff, p = a^b_eff; group carries by full lookahead equations; sum = p ^ carries.
- Stage k (1..NSTAGES) computes bit slice [(k-1)*SW +: SW], where SW = GROUP*GROUPS_PER_STAGE, using the carry registered by stage k-1 (stage 1 uses c0).
- Stage k registers: its slice sum, carry out, the remaining operand bits, and sum bits from earlier stages. The last stage also registers the carry into the MSB, for ovf.
- Latency: a beat accepted at edge n is presented on s/cout/ovf with out_valid=1 after edge n+NSTAGES-1. Throughput is 1 beat/cycle when out_ready=1.
- Handshake:
  - Global advance enable en = out_ready | ~out_valid.
  - in_ready = en, combinational; no dependence on in_valid.
  - A beat is accepted when in_valid & in_ready.
  - When en=0, every stage register and its valid bit hold.
  - When en=1, every stage shifts; stage 1 valid <= in_valid.
  - Bubbles propagate as valid=0; data in bubbles is don't-care but must not toggle out_* while out_valid=0.
- Output stability: while out_valid=1 and out_ready=0, s/cout/ovf hold stable.
- Output beats emerge in acceptance order, with no loss and no duplication.
- Simultaneous output and input (out_valid & out_ready & in_valid): the output retires and the input is accepted in the same edge.
- NSTAGES=1: degenerates to a single registered stage with latency 1 and the same handshake.
- cout/ovf are computed on the unsaturated result.

Optional Feature:
- Macro CLA_PIPE_SAT_EN.
- Defined: when ovf=1, s is replaced at the output register by the signed saturation value: 0x7F..F if the MSB of a is 0, else 0x80..0. cout and ovf are still reported unmodified.
- Undefined: s is always the wrapped modulo result; no saturation logic is instantiated.

Test Plan:
- Defaults, add: a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1 -> after 2 cycles s=0x5555, cout=0, ovf=0.
- Cross-stage carry:
  - 0x00FF+0x0001 -> s=0x0100.
  - 0xFFFF+0x0001 -> s=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> s=0x8000, ovf=1.
- Subtract:
  - 0x0005-0x0007, cin=0 -> s=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> s=0x7FFF, cout=1, ovf=1.
  - 0x0010-0x0001 with cin=1 -> s=0x000E.
- Backpressure stream: 16 random beats back-to-back, out_ready toggling 1,0,0,1,... -> results in order vs a reference model, none lost or duplicated, outputs stable while stalled, in_ready==(out_ready|~out_valid) every cycle.
- Reset mid-stream: 2 beats in flight, rst=1 for 1 cycle -> out_valid=0 next cycle; those beats never appear; the next accepted beat emerges with correct result after 2 cycles.
- CLA_PIPE_SAT_EN defined:
  - 0x7FFF+0x0001 -> s=0x7FFF, ovf=1.
  - 0x8000-0x0001 -> s=0x8000, ovf=1.
  - Undefined: same stimuli give 0x8000 / 0x7FFF.
